csr_access_ctrl: RTL and testbench
==================================

Name: csr_access_ctrl

Overview:
- Pipeline-side initiator for the CSR register file. It accepts one decoded Zicsr instruction (CSRRW/RS/RC and the immediate forms) from the execute stage.
- It reads the current CSR value and computes the read-modify-write result. When a write is architecturally required, it issues a single-cycle write strobe and waits for the write-done handshake.
- It returns the old value for rd and stalls the pipeline while the access is in flight.

Parameters:
- WRITE_TIMEOUT, 16, max cycles in WAIT_DONE before the access is aborted as illegal; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  execute stage presents a CSR instruction.
- req_ready  out  1  controller can accept a request.
- req_func3  in  3  instruction func3.
- req_csr_addr  in  12  CSR address.
- req_rs1_idx  in  5  rs1 index; doubles as uimm for the immediate forms.
- req_rs1_data  in  32  rs1 register value.
- req_rd_idx  in  5  destination register.
- csr_addr  out  12  address to the CSR unit; held stable from READ through WAIT_DONE.
- csr_func3  out  3  latched func3, passed through.
- csr_imm  out  5  latched uimm, passed through.
- csr_wdata  out  32  value to write.
- csr_rdata  in  32  combinational read data from the CSR unit.
- csr_write_enable  out  1  write strobe.
- csr_write_done  in  1  write acknowledge, arrives one cycle after the strobe.
- rsp_valid  out  1  one-cycle pulse: result available.
- rsp_rd_idx  out  5  destination register index; 0 when illegal.
- rsp_rd_data  out  32  old CSR value; 0 when illegal.
- rsp_illegal  out  1  raise an illegal-instruction exception; valid with rsp_valid.
- stall  out  1  pipeline freeze; high whenever state != IDLE.

Behaviour:
- Reset state: IDLE. While rst=1, every output is 0, including req_ready. All latched fields and the timeout counter clear to 0.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch func3, addr, rs1_idx, rs1_data and rd_idx, then go to READ.
- READ (1 cycle):
  - Drive csr_addr and capture csr_rdata into old_q.
  - Compute new value:
    - 001: rs1_data
    - 010: old | rs1_data
    - 011: old & ~rs1_data
    - 101: zext(uimm)
    - 110: old | zext(uimm)
    - 111: old & ~zext(uimm)
  - write_needed is 1 for 001/101. For 010/011/110/111 it is 1 only when rs1_idx != 0.
  - func3 of 000 or 100: illegal, go to RESP.
  - addr[11:10]==2'b11 with write_needed=1: illegal (write to read-only CSR), no write, go to RESP.
  - write_needed=0: go to RESP with no write.
  - Otherwise register the new value into csr_wdata and go to WRITE.
- WRITE (1 cycle):
  - csr_write_enable=1 for exactly this cycle; csr_wdata is stable.
  - Go to WAIT_DONE and clear the timeout counter.
- WAIT_DONE:
  - csr_write_enable=0.
  - csr_write_done=1: go to RESP, legal.
  - Otherwise increment the counter. When counter == WRITE_TIMEOUT-1 without done, go to RESP with illegal=1.
  - A csr_write_done seen in any other state is ignored.
- RESP (1 cycle):
  - rsp_valid=1.
  - rd_data = old_q and rd_idx = latched rd, or both 0 if illegal.
  - Go to IDLE. A new request can be accepted the next cycle.
- Latency, from acceptance edge to rsp_valid:
  - 2 cycles without a write.
  - 4 cycles with a write and prompt done.
  - At most 3+WRITE_TIMEOUT cycles.
- Reading rd is always performed, even when rd_idx=0; the register file discards x0 writes.
- Reset asserted mid-operation: return to IDLE on the next edge. csr_write_enable drops, and no rsp_valid is produced for the aborted request.
- req_valid asserted while busy is not accepted (req_ready=0); the upstream stage holds it because stall=1.

Decomposition:
- Shared package csr_pkg holds:
  - func3 encodings (CSRRW=3'b001 ... CSRRCI=3'b111).
  - CSR address constants (MSTATUS, MIE, MTVEC, MSCRATCH, MEPC, CYCLE, etc.).
  - The state enum (IDLE, READ, WRITE, WAIT_DONE, RESP).
- One natural combinational sub-module, csr_rmw_alu, takes func3, old, rs1_data, uimm and rs1_idx. It outputs new_value, write_needed and func3_illegal.

Test Plan:
- CSRRW to MSCRATCH (0x340), rs1_data=0xDEADBEEF, old=0x0: write strobe 2 cycles after acceptance with wdata=0xDEADBEEF; done on the next cycle; rsp_valid 4 cycles after acceptance with rd_data=0x0, illegal=0.
- CSRRS to MSTATUS, old=0x00000008, rs1_data=0x00000080, then CSRRC with rs1_data=0x00000008: first wdata=0x00000088, rd_data=0x8; second wdata=0x00000080, rd_data=0x88.
- CSRRS to CYCLE (0xC00) with rs1_idx=0: no write strobe; rsp_valid 2 cycles after acceptance; rd_data=csr_rdata; illegal=0.
- CSRRW to MVENDORID (0xF11): no strobe; rsp_illegal=1 with rd_data=0 and rd_idx=0. Repeat with func3=3'b100: same result.
- CSRRWI uimm=5'h1F to MIE, with csr_write_done held 0: strobe once with wdata=0x1F; after 16 cycles in WAIT_DONE, rsp_illegal=1.
- rst pulsed the cycle after WRITE: csr_write_enable=0, stall=0 and req_ready=1 the cycle after rst deasserts; no rsp_valid for the aborted request; the next CSRRW completes normally.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared encodings for the CSR access path: Zicsr func3 values, common CSR
// addresses and the access controller state type.
package csr_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        WRITE     = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

endpackage

// File: rtl/csr_rmw_alu.sv
// Read-modify-write value for a Zicsr instruction, plus whether the
// instruction architecturally writes the CSR and whether func3 is valid.
module csr_rmw_alu
    import csr_pkg::*;
(
    input  logic [2:0]        func3,
    input  logic [DATA_W-1:0] old_value,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [4:0]        uimm,
    input  logic [4:0]        rs1_idx,
    output logic [DATA_W-1:0] new_value,
    output logic              write_needed,
    output logic              func3_illegal
);

    logic [DATA_W-1:0] operand;

    // func3[2] selects the zero-extended immediate forms
    assign operand = func3[2] ? {{(DATA_W-5){1'b0}}, uimm} : rs1_data;

    always_comb begin
        new_value     = old_value;
        write_needed  = 1'b0;
        func3_illegal = 1'b0;
        case (func3)
            F3_CSRRW, F3_CSRRWI: begin
                new_value    = operand;
                write_needed = 1'b1;
            end
            F3_CSRRS, F3_CSRRSI: begin
                new_value    = old_value | operand;
                write_needed = (rs1_idx != 5'd0);
            end
            F3_CSRRC, F3_CSRRCI: begin
                new_value    = old_value & ~operand;
                write_needed = (rs1_idx != 5'd0);
            end
            default: func3_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Pipeline-side CSR access sequencer: read, optional single-cycle write with
// done handshake and timeout, then a one-cycle response carrying the old value.
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int WRITE_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_func3,
    input  logic [11:0] req_csr_addr,
    input  logic [4:0]  req_rs1_idx,
    input  logic [31:0] req_rs1_data,
    input  logic [4:0]  req_rd_idx,
    output logic [11:0] csr_addr,
    output logic [2:0]  csr_func3,
    output logic [4:0]  csr_imm,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic        csr_write_enable,
    input  logic        csr_write_done,
    output logic        rsp_valid,
    output logic [4:0]  rsp_rd_idx,
    output logic [31:0] rsp_rd_data,
    output logic        rsp_illegal,
    output logic        stall
);

    localparam logic [7:0] TMO_LAST = 8'(WRITE_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [2:0]        func3_q;
    logic [11:0]       addr_q;
    logic [4:0]        rs1_idx_q;
    logic [DATA_W-1:0] rs1_data_q;
    logic [4:0]        rd_idx_q;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] wdata_q;
    logic              illegal_q;
    logic [7:0]        cnt_q;

    logic [DATA_W-1:0] alu_new;
    logic              alu_wn;
    logic              alu_f3_ill;
    logic              read_illegal;

    csr_rmw_alu u_alu (
        .func3         (func3_q),
        .old_value     (csr_rdata),
        .rs1_data      (rs1_data_q),
        .uimm          (rs1_idx_q),
        .rs1_idx       (rs1_idx_q),
        .new_value     (alu_new),
        .write_needed  (alu_wn),
        .func3_illegal (alu_f3_ill)
    );

    // addr[11:10]==11 marks the read-only CSR space
    assign read_illegal = alu_f3_ill || ((addr_q[11:10] == 2'b11) && alu_wn);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_valid) state_d = READ;
            READ:      state_d = (read_illegal || !alu_wn) ? RESP : WRITE;
            WRITE:     state_d = WAIT_DONE;
            WAIT_DONE: if (csr_write_done || (cnt_q == TMO_LAST)) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            func3_q    <= '0;
            addr_q     <= '0;
            rs1_idx_q  <= '0;
            rs1_data_q <= '0;
            rd_idx_q   <= '0;
            old_q      <= '0;
            wdata_q    <= '0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (req_valid) begin
                    func3_q    <= req_func3;
                    addr_q     <= req_csr_addr;
                    rs1_idx_q  <= req_rs1_idx;
                    rs1_data_q <= req_rs1_data;
                    rd_idx_q   <= req_rd_idx;
                    illegal_q  <= 1'b0;
                end
                READ: begin
                    old_q     <= csr_rdata;
                    illegal_q <= read_illegal;
                    if (state_d == WRITE) wdata_q <= alu_new;
                end
                WRITE: cnt_q <= '0;
                WAIT_DONE: if (!csr_write_done) begin
                    if (cnt_q == TMO_LAST) illegal_q <= 1'b1;
                    else                   cnt_q     <= cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced low while reset is held, whatever the state register holds
    assign req_ready        = !rst && (state_q == IDLE);
    assign stall            = !rst && (state_q != IDLE);
    assign csr_write_enable = !rst && (state_q == WRITE);
    assign rsp_valid        = !rst && (state_q == RESP);
    assign rsp_illegal      = rsp_valid && illegal_q;
    assign rsp_rd_idx       = (rsp_valid && !illegal_q) ? rd_idx_q : 5'd0;
    assign rsp_rd_data      = (rsp_valid && !illegal_q) ? old_q : '0;
    assign csr_addr         = rst ? 12'd0 : addr_q;
    assign csr_func3        = rst ? 3'd0 : func3_q;
    assign csr_imm          = rst ? 5'd0 : rs1_idx_q;
    assign csr_wdata        = rst ? '0 : wdata_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Scoreboard bench for csr_access_ctrl with a behavioural CSR file that
// answers reads combinationally and acknowledges writes one cycle later.
module tb_csr_access_ctrl;
    import csr_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_func3 = '0;
    logic [11:0] req_csr_addr = '0;
    logic [4:0]  req_rs1_idx = '0;
    logic [31:0] req_rs1_data = '0;
    logic [4:0]  req_rd_idx = '0;
    logic [11:0] csr_addr;
    logic [2:0]  csr_func3;
    logic [4:0]  csr_imm;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_write_enable;
    logic        csr_write_done = 1'b0;
    logic        rsp_valid;
    logic [4:0]  rsp_rd_idx;
    logic [31:0] rsp_rd_data;
    logic        rsp_illegal;
    logic        stall;

    logic [31:0] mem [0:4095];
    bit          done_en = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        ill;
        int          lat;
        int          acc;
    } rsp_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          acc;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    csr_access_ctrl #(.WRITE_TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_func3        (req_func3),
        .req_csr_addr     (req_csr_addr),
        .req_rs1_idx      (req_rs1_idx),
        .req_rs1_data     (req_rs1_data),
        .req_rd_idx       (req_rd_idx),
        .csr_addr         (csr_addr),
        .csr_func3        (csr_func3),
        .csr_imm          (csr_imm),
        .csr_wdata        (csr_wdata),
        .csr_rdata        (csr_rdata),
        .csr_write_enable (csr_write_enable),
        .csr_write_done   (csr_write_done),
        .rsp_valid        (rsp_valid),
        .rsp_rd_idx       (rsp_rd_idx),
        .rsp_rd_data      (rsp_rd_data),
        .rsp_illegal      (rsp_illegal),
        .stall            (stall)
    );

    assign csr_rdata = mem[csr_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // CSR file responder: commit on strobe, acknowledge the following cycle
    initial begin
        forever begin
            @(negedge clk);
            if (csr_write_enable && done_en) begin
                mem[csr_addr] = csr_wdata;
                @(posedge clk);
                #1 csr_write_done = 1'b1;
                @(posedge clk);
                #1 csr_write_done = 1'b0;
            end
        end
    end

    // Output monitor: pops scoreboard entries as the DUT produces them
    initial begin
        wr_t  w;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!rst) check("ready_vs_stall", 32'(req_ready), 32'(!stall));
            if (csr_write_enable) begin
                check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(csr_addr), 32'(w.addr));
                    check("wr_data", csr_wdata, w.data);
                    check("wr_lat", 32'(cyc - w.acc + 1), 32'd2);
                end
            end
            if (rsp_valid) begin
                check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    check("rsp_data", rsp_rd_data, r.data);
                    check("rsp_idx", 32'(rsp_rd_idx), 32'(r.idx));
                    check("rsp_illegal", 32'(rsp_illegal), 32'(r.ill));
                    check("rsp_lat", 32'(cyc - r.acc + 1), 32'(r.lat));
                end
            end
        end
    end

    task automatic send(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] ri,
                        input logic [31:0] rdat, input logic [4:0] rdi, input bit want_rsp);
        logic [31:0] old, opnd, nv;
        bit   wn, ill;
        rsp_t r;
        wr_t  w;
        int   n;
        old  = mem[a];
        opnd = f3[2] ? {27'd0, ri} : rdat;
        case (f3[1:0])
            2'b01:   nv = opnd;
            2'b10:   nv = old | opnd;
            2'b11:   nv = old & ~opnd;
            default: nv = old;
        endcase
        wn  = (f3[1:0] == 2'b01) || (ri != 5'd0);
        ill = (f3[1:0] == 2'b00) || ((a[11:10] == 2'b11) && wn);

        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        req_func3    = f3;
        req_csr_addr = a;
        req_rs1_idx  = ri;
        req_rs1_data = rdat;
        req_rd_idx   = rdi;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        r.acc = cyc;
        w.acc = cyc;
        if (ill) begin
            r.data = '0; r.idx = '0; r.ill = 1'b1; r.lat = 2;
        end else if (!wn) begin
            r.data = old; r.idx = rdi; r.ill = 1'b0; r.lat = 2;
        end else begin
            w.addr = a;
            w.data = nv;
            wr_q.push_back(w);
            if (done_en) begin
                r.data = old; r.idx = rdi; r.ill = 1'b0; r.lat = 4;
            end else begin
                r.data = '0; r.idx = '0; r.ill = 1'b1; r.lat = 3 + TMO;
            end
        end
        if (want_rsp) rsp_q.push_back(r);
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(rsp_q.size() + wr_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) mem[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_we", 32'(csr_write_enable), 32'd0);
        check("rst_addr", 32'(csr_addr), 32'd0);
        check("rst_wdata", csr_wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        send(F3_CSRRW, CSR_MSCRATCH, 5'd5, 32'hDEADBEEF, 5'd10, 1'b1);
        drain();

        mem[CSR_MSTATUS] = 32'h0000_0008;
        send(F3_CSRRS, CSR_MSTATUS, 5'd3, 32'h0000_0080, 5'd11, 1'b1);
        drain();
        send(F3_CSRRC, CSR_MSTATUS, 5'd3, 32'h0000_0008, 5'd12, 1'b1);
        drain();
        check("mstatus_final", mem[CSR_MSTATUS], 32'h0000_0080);

        mem[CSR_CYCLE] = 32'h1234_5678;
        send(F3_CSRRS, CSR_CYCLE, 5'd0, 32'hFFFF_FFFF, 5'd13, 1'b1);
        drain();

        send(F3_CSRRW, CSR_MVENDORID, 5'd4, 32'h1, 5'd14, 1'b1);
        drain();
        send(3'b100, CSR_MSCRATCH, 5'd4, 32'h1, 5'd15, 1'b1);
        drain();
        send(3'b000, CSR_MSCRATCH, 5'd4, 32'h1, 5'd15, 1'b1);
        drain();

        send(F3_CSRRSI, CSR_MSTATUS, 5'd0, 32'h0, 5'd16, 1'b1);
        drain();
        mem[CSR_MTVEC] = 32'h0000_00FF;
        send(F3_CSRRCI, CSR_MTVEC, 5'h0A, 32'h0, 5'd17, 1'b1);
        drain();
        send(F3_CSRRWI, CSR_CYCLE, 5'h03, 32'h0, 5'd18, 1'b1);
        drain();
        send(F3_CSRRS, CSR_CYCLE, 5'd2, 32'h1, 5'd19, 1'b1);
        drain();

        done_en = 1'b0;
        send(F3_CSRRWI, CSR_MIE, 5'h1F, 32'h0, 5'd20, 1'b1);
        drain();
        done_en = 1'b1;

        // Reset arrives while the access sits in WAIT_DONE
        send(F3_CSRRW, CSR_MSCRATCH, 5'd7, 32'hCAFE_0001, 5'd21, 1'b0);
        n = 0;
        @(negedge clk);
        while (!csr_write_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_strobe_seen", 32'(csr_write_enable), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_rst_we", 32'(csr_write_enable), 32'd0);
        check("abort_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_we", 32'(csr_write_enable), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        repeat (6) @(negedge clk);
        drain();

        send(F3_CSRRW, CSR_MSCRATCH, 5'd6, 32'h0BAD_F00D, 5'd22, 1'b1);
        drain();
        check("mscratch_final", mem[CSR_MSCRATCH], 32'h0BAD_F00D);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
